// File: rtl/consmax_lut_loader_if.sv
// consmax_lut_loader_if
//   Groups the loader's two buses: the configuration byte stream (valid/ready)
//   and the LUT write port that every ConSmax lane shares.
//   Signals:
//     in_data   config byte, low byte of each word first
//     in_valid  in_data valid
//     in_ready  loader accepts a byte (transfer when in_valid & in_ready)
//     lut_waddr {lut_sel, entry_index}; MSB selects LUT1 (1) or LUT0 (0)
//     lut_wen   one-cycle write strobe
//     lut_wdata FP entry {sign, exp[7:0], mant[6:0]}
//   Modports:
//     master  the loader: consumes the byte stream, drives the LUT write port
//     slave   the environment: sources bytes, observes LUT writes
interface consmax_lut_loader_if #(
  parameter int unsigned LUT_ADDR = 4,
  parameter int unsigned LUT_DATA = 16,
  parameter int unsigned BYTE_BIT = 8
);
  logic [BYTE_BIT-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [LUT_ADDR:0]   lut_waddr;
  logic                lut_wen;
  logic [LUT_DATA-1:0] lut_wdata;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output lut_waddr,
    output lut_wen,
    output lut_wdata
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  lut_waddr,
    input  lut_wen,
    input  lut_wdata
  );
endinterface

// File: rtl/consmax_lut_loader.sv
// consmax_lut_loader
//   Write-side programmer for the ConSmax INT-to-FP lookup tables. Assembles
//   16-bit entries from a byte stream, writes LUT0 then LUT1 entry by entry,
//   then checks a trailing 16-bit XOR checksum against the written words.
//   Ports:
//     clk      clock
//     rstn     asynchronous active-low reset
//     start    one-cycle pulse, begins a load (only taken when idle)
//     abort    synchronous abort back to idle; wins over start
//     bus      master side of consmax_lut_loader_if (byte stream + LUT write)
//     busy     load in progress; LUT reads must not be issued
//     done     one-cycle pulse when the checksum is evaluated
//     chk_err  checksum mismatch on the last load; held until next start
//   All outputs are registered; lut_waddr/lut_wdata hold between writes.
module consmax_lut_loader #(
  parameter int unsigned LUT_ADDR = 4,
  parameter int unsigned LUT_DATA = 16,
  parameter int unsigned BYTE_BIT = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  consmax_lut_loader_if.master       bus,
  output logic                       busy,
  output logic                       done,
  output logic                       chk_err
);

  typedef enum logic [2:0] {
    IDLE,
    RX_LO,
    RX_HI,
    WRITE,
    TRL_LO,
    TRL_HI,
    CHECK
  } state_t;

  state_t state_q, state_d;

  logic [LUT_ADDR:0]   cnt_q, cnt_d;
  logic [BYTE_BIT-1:0] lo_q, lo_d;
  logic [LUT_DATA-1:0] csum_q, csum_d;

  logic                ready_q, ready_d;
  logic                wen_q, wen_d;
  logic [LUT_ADDR:0]   waddr_q, waddr_d;
  logic [LUT_DATA-1:0] wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer;
  logic [LUT_DATA-1:0] word;

  // in_ready is a registered copy of the state decode, so it is stable for
  // the whole cycle and the transfer condition needs no combinational path
  // from in_valid back to in_ready.
  assign xfer = bus.in_valid & ready_q;
  assign word = {bus.in_data, lo_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    csum_d  = csum_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RX_LO;
          cnt_d   = '0;
          csum_d  = '0;
          err_d   = 1'b0;
        end
      end
      RX_LO: begin
        if (xfer) begin
          lo_d    = bus.in_data;
          state_d = RX_HI;
        end
      end
      RX_HI: begin
        // The write port is loaded as the high byte arrives so the strobe
        // appears in the very next cycle; the checksum folds in here too.
        if (xfer) begin
          waddr_d = cnt_q;
          wdata_d = word;
          csum_d  = csum_q ^ word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == '1) begin
          state_d = TRL_LO;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = RX_LO;
        end
      end
      TRL_LO: begin
        if (xfer) begin
          lo_d    = bus.in_data;
          state_d = TRL_HI;
        end
      end
      TRL_HI: begin
        if (xfer) begin
          err_d   = (word != csum_q);
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops any byte taken this cycle: the write port keeps its last
    // written values and chk_err keeps the previous load's verdict.
    if (abort) begin
      state_d = IDLE;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
    end

    ready_d = (state_d == RX_LO) || (state_d == RX_HI) ||
              (state_d == TRL_LO) || (state_d == TRL_HI);
    busy_d  = (state_d != IDLE) && (state_d != CHECK);
    wen_d   = (state_d == WRITE);
    done_d  = (state_d == CHECK);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      lo_q    <= '0;
      csum_q  <= '0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      csum_q  <= csum_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.lut_wen   = wen_q;
  assign bus.lut_waddr = waddr_q;
  assign bus.lut_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign chk_err       = err_q;

endmodule

// File: tb/tb_consmax_lut_loader.sv
// tb_consmax_lut_loader
//   Self-checking bench for consmax_lut_loader. A table of load scenarios
//   (data pattern, trailer, stall/abort/start-while-busy placement, expected
//   write count, done and chk_err) is applied in a loop; each load's words
//   are generated here and the expected writes/checksum come from a plain
//   array model. Hand-written sequences cover reset, start+abort and a reset
//   in the middle of a load.
module tb_consmax_lut_loader;

  localparam int unsigned LUT_ADDR = 4;
  localparam int unsigned LUT_DATA = 16;
  localparam int unsigned BYTE_BIT = 8;
  localparam int          N_ENT    = 2 ** (LUT_ADDR + 1);

  logic clk;
  logic rstn;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic chk_err;

  consmax_lut_loader_if #(
    .LUT_ADDR(LUT_ADDR),
    .LUT_DATA(LUT_DATA),
    .BYTE_BIT(BYTE_BIT)
  ) bus ();

  consmax_lut_loader #(
    .LUT_ADDR(LUT_ADDR),
    .LUT_DATA(LUT_DATA),
    .BYTE_BIT(BYTE_BIT)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .abort  (abort),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .chk_err(chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [20:0] cap_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (bus.lut_wen) cap_q.push_back({bus.lut_waddr, bus.lut_wdata});
    if (done) done_cnt++;
  end

  typedef struct {
    bit rand_data;
    bit rand_gaps;
    int trailer_xor;
    int stall_at;
    int stall_n;
    int abort_at;
    int start_at;
    int exp_writes;
    int exp_done;
    int exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    for (int k = 0; k < gap; k++) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
    end
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input vec_t v, input string tag);
    logic [15:0] w [N_ENT];
    logic [15:0] csum;
    logic [15:0] trl;
    logic        err_before;
    bit          aborted;
    int          gap;
    cap_q.delete();
    done_cnt = 0;
    csum = '0;
    for (int i = 0; i < N_ENT; i++) begin
      w[i] = v.rand_data ? 16'($urandom) : (16'h3F80 ^ 16'(i));
      csum ^= w[i];
    end
    trl = csum ^ 16'(v.trailer_xor);

    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "/busy_after_start"}, busy, 1);
    check({tag, "/ready_after_start"}, bus.in_ready, 1);
    check({tag, "/chk_err_cleared"}, chk_err, 0);

    aborted = 1'b0;
    for (int i = 0; i < N_ENT && !aborted; i++) begin
      if (i == v.start_at) begin
        bus.in_valid = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "/busy_after_restart"}, busy, 1);
      end
      gap = v.rand_gaps ? int'($urandom_range(0, 2)) : 0;
      send_byte(w[i][7:0], gap);
      if (i == v.stall_at) begin
        bus.in_valid = 1'b0;
        for (int k = 0; k < v.stall_n; k++) begin
          tick();
          check({tag, "/stall_no_wen"}, bus.lut_wen, 0);
          check({tag, "/stall_ready"}, bus.in_ready, 1);
        end
      end
      gap = v.rand_gaps ? int'($urandom_range(0, 2)) : 0;
      send_byte(w[i][15:8], gap);
      check({tag, "/wen_after_hi"}, bus.lut_wen, 1);
      check({tag, "/waddr"}, 32'(bus.lut_waddr), 32'(i));
      check({tag, "/wdata"}, 32'(bus.lut_wdata), 32'(w[i]));
      check({tag, "/ready_in_write"}, bus.in_ready, 0);
      if (i == v.abort_at) begin
        err_before = chk_err;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check({tag, "/abort_busy"}, busy, 0);
        check({tag, "/abort_ready"}, bus.in_ready, 0);
        check({tag, "/abort_wen"}, bus.lut_wen, 0);
        check({tag, "/abort_done"}, done, 0);
        check({tag, "/abort_chk_err"}, chk_err, err_before);
        bus.in_valid = 1'b1;
        repeat (10) begin
          bus.in_data = 8'($urandom);
          tick();
        end
        bus.in_valid = 1'b0;
        aborted = 1'b1;
      end
    end

    if (!aborted) begin
      send_byte(trl[7:0], 0);
      send_byte(trl[15:8], 0);
      bus.in_valid = 1'b0;
      check({tag, "/done_pulse"}, done, 1);
      check({tag, "/busy_in_check"}, busy, 0);
      check({tag, "/ready_in_check"}, bus.in_ready, 0);
      check({tag, "/chk_err"}, chk_err, 32'(v.exp_err));
      tick();
      check({tag, "/done_one_cycle"}, done, 0);
      check({tag, "/chk_err_hold"}, chk_err, 32'(v.exp_err));
    end
    tick();

    check({tag, "/write_count"}, 32'(cap_q.size()), 32'(v.exp_writes));
    check({tag, "/done_count"}, 32'(done_cnt), 32'(v.exp_done));
    for (int i = 0; i < cap_q.size() && i < N_ENT; i++) begin
      check({tag, "/cap_addr"}, 32'(cap_q[i][20:16]), 32'(i));
      check({tag, "/cap_data"}, 32'(cap_q[i][15:0]), 32'(w[i]));
    end
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{0, 0, 0,                         -1, 0, -1, -1, 32, 1, 0};
    vecs[1] = '{0, 0, 1,                         -1, 0, -1, -1, 32, 1, 1};
    vecs[2] = '{0, 0, 0,                         16, 5, -1, -1, 32, 1, 0};
    vecs[3] = '{0, 0, 0,                         -1, 0,  3, -1,  4, 0, 0};
    vecs[4] = '{0, 0, 0,                         -1, 0, -1, 10, 32, 1, 0};
    vecs[5] = '{1, 1, 0,                         -1, 0, -1, -1, 32, 1, 0};
    vecs[6] = '{1, 1, int'($urandom_range(1, 65535)), -1, 0, -1, -1, 32, 1, 1};
    vecs[7] = '{1, 1, 0,                          7, 3, -1, -1, 32, 1, 0};

    rstn         = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", busy, 0);
    check("reset/ready", bus.in_ready, 0);
    check("reset/wen", bus.lut_wen, 0);
    check("reset/waddr", 32'(bus.lut_waddr), 0);
    check("reset/wdata", 32'(bus.lut_wdata), 0);
    check("reset/done", done, 0);
    check("reset/chk_err", chk_err, 0);
    rstn = 1'b1;
    tick();

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort/busy", busy, 0);
    check("start_abort/ready", bus.in_ready, 0);
    tick();
    check("start_abort/busy_later", busy, 0);

    for (int v = 0; v < 8; v++) begin
      run_load(vecs[v], $sformatf("vec%0d", v));
    end

    // Reset in the middle of entry 7, then a fresh load must restart at 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_byte(8'h11 + 8'(i), 0);
      send_byte(8'h40, 0);
    end
    send_byte(8'hAA, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("midreset/busy", busy, 0);
    check("midreset/ready", bus.in_ready, 0);
    check("midreset/wen", bus.lut_wen, 0);
    check("midreset/waddr", 32'(bus.lut_waddr), 0);
    check("midreset/wdata", 32'(bus.lut_wdata), 0);
    check("midreset/done", done, 0);
    check("midreset/chk_err", chk_err, 0);
    bus.in_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    run_load(vecs[0], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/consmax_lut_loader.md
Name: consmax_lut_loader

Overview:
Write-side programmer for the ConSmax INT-to-FP lookup tables. It takes a byte stream from the configuration port (SPI deserializer) over a valid/ready handshake and assembles 16-bit FP entries. It then issues single-cycle write strobes on the LUT write interface (address, write enable, write data) shared by every ConSmax lane. It sequences both LUTs, verifies a trailing XOR checksum, and asserts busy so the datapath does not read the LUTs mid-load.

Parameters:
LUT_ADDR, 4, per-LUT address width; each LUT holds 2**LUT_ADDR entries.
LUT_DATA, 16, LUT entry width (sign, 8-bit exponent, 7-bit mantissa); fixed at 2 bytes.
BYTE_BIT, 8, width of the input byte stream.

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a full load; ignored while busy=1
abort  input  1  synchronous abort; returns to IDLE, no further writes
in_data  input  BYTE_BIT  config byte; low byte of each word first
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte; transfer occurs when in_valid&in_ready
lut_waddr  output  LUT_ADDR+1  bit[LUT_ADDR] selects LUT1 (1) or LUT0 (0); lower bits are the entry index
lut_wen  output  1  one-cycle write strobe
lut_wdata  output  LUT_DATA  FP entry
busy  output  1  load in progress; datapath must not issue LUT reads
done  output  1  one-cycle pulse at end of load
chk_err  output  1  checksum mismatch on last load; holds until next accepted start

Behaviour:
- Reset values of all outputs are 0. Internal address counter, byte holding register and checksum accumulator also reset to 0.
- All outputs are registered.
- States:
  - IDLE: in_ready=0, busy=0. A start pulse moves to RX_LO; busy=1 and in_ready=1 from the next cycle. On start, the address counter and checksum clear and chk_err clears.
  - RX_LO: accept a byte into the low half of the holding register, then go to RX_HI.
  - RX_HI: accept the high byte. Next cycle go to WRITE.
  - WRITE: lut_wen=1 for exactly one cycle, with lut_waddr = counter and lut_wdata = {hi,lo}. in_ready=0 in this cycle. The checksum is updated as checksum ^= word.
    - If counter = 2**(LUT_ADDR+1)-1, go to TRL_LO.
    - Otherwise increment the counter and return to RX_LO.
  - TRL_LO / TRL_HI: accept a 2-byte trailer (low byte first).
  - CHECK: one cycle after the trailer high byte. Compare the trailer with the checksum: chk_err = (trailer != checksum), done=1 for one cycle, busy=0, in_ready=0. Then go to IDLE.
- Timing:
  - A high byte accepted in cycle t gives lut_wen=1 in cycle t+1.
  - Minimum cost is 3 cycles per entry. A full default load is 32 entries plus the trailer, with 2*32+2 byte transfers.
  - Back-pressure: in_ready stays high in RX/TRL states regardless of in_valid. Stall cycles (in_valid=0) hold state indefinitely with no timeout.
- Address order: LUT0 entries 0..2**LUT_ADDR-1 first, then LUT1 entries 0..2**LUT_ADDR-1. The counter is LUT_ADDR+1 bits wide and never wraps within a load.
- lut_waddr and lut_wdata hold their last written values when lut_wen=0.
- start while busy=1 is ignored and the load continues unaffected.
- start and abort in the same cycle: abort wins and the block stays in IDLE.
- abort in any state:
  - Next cycle: IDLE, busy=0, in_ready=0, lut_wen=0, done=0, chk_err unchanged.
  - Entries already written stay in the LUTs. A partial load is the software's responsibility.
- abort in the WRITE cycle: that write completes (lut_wen already registered), then the block goes to IDLE.
- Asynchronous reset mid-load: all outputs drop to 0 immediately, with no pending write.
- in_data is ignored when in_ready=0.

Test Plan:
- Nominal load:
  - Stimulus: start; words w_i = 0x3F80 ^ i for i=0..31, streamed with in_valid held high; trailer 0x0000.
  - Required: 32 lut_wen pulses with lut_waddr 0x00..0x1F in order and lut_wdata = w_i. Exactly one done pulse, chk_err=0, busy high from the cycle after start to the CHECK cycle.
- Checksum error: same data with trailer 0x0001 -> all 32 writes occur, done pulses, chk_err=1; a new start clears chk_err to 0.
- Back-pressure/stall:
  - Stimulus: insert 5 idle cycles (in_valid=0) between the low and high byte of entry 16.
  - Required: no lut_wen until the high byte is accepted; entry 16 written at lut_waddr=0x10 (LUT1 index 0) one cycle after acceptance.
- Abort:
  - Stimulus: assert abort after entry 3's high byte is accepted (the WRITE cycle follows).
  - Required: the write to addr 3 completes, then busy=0, in_ready=0, no done pulse, and no further lut_wen despite in_valid=1.
- Start while busy: pulse start during entry 10 -> the sequence continues unchanged, addresses are not reset, exactly 32 writes and one done.
- Reset mid-load: drop rstn during entry 7 -> all outputs 0 asynchronously. After release, a fresh start writes from addr 0.
